q_twos_to_signmag: RTL and testbench

Bit-serial converter from an N-bit two's-complement fixed-point word (Q fraction bits) to the N-bit sign-magnitude Q format used by the team's fixed-point math blocks. It is the reverse of the existing sign-magnitude-to-two's-complement negation path. It sits at the output of two's-complement datapaths, before results re-enter the Q-format arithmetic units. Valid/ready handshakes are used on both sides. One word is processed at a time, at one magnitude bit per clock.

---
 rtl/q_twos_to_signmag.sv | 138 +++++++++++++
 tb/tb_q_twos_to_signmag.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/q_twos_to_signmag.sv
// q_twos_to_signmag
// Bit-serial two's-complement to sign-magnitude converter.
// The magnitude is produced one bit per clock, LSB first, with the classic
// "copy up to and including the first 1, then invert" negation rule.
//
// Handshake contract (both sides): a word moves across an interface on a
// rising edge where valid and ready are both high. Valid, once raised, holds
// with its data until that edge.
//
// The most negative input has no representable magnitude. It saturates to
// {1, all ones} and raises o_ovf for that result only.
module q_twos_to_signmag #(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_data,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [N-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic         o_ovf,
   output logic         o_busy,
   output logic [1:0]   o_state
);

   // Q only labels the fixed-point format; the conversion does not depend on it.
   // An illegal parameter set elaborates this empty marker scope.
   if ((N < 3) || (Q > N - 2)) begin : g_bad_params
   end

   localparam int CW = $clog2(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [CW-1:0] cnt;
   logic [N-2:0]  sreg;
   logic [N-2:0]  mag;
   logic          sign;
   logic          seen_one;

   logic          accept;
   logic          last_bit;
   logic          out_bit;
   logic          seen_one_d;

   assign accept     = (state == S_IDLE) && i_valid;
   assign last_bit   = (cnt == CW'(N - 2));
   // Negating: bits after the first 1 are inverted; positive words pass through.
   assign out_bit    = sreg[0] ^ (sign & seen_one);
   assign seen_one_d = seen_one | sreg[0];
   assign o_state    = state;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: if (i_valid) state_d = S_CONV;
         S_CONV: if (last_bit) state_d = S_DONE;
         S_DONE: if (i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status flags are registered copies of the upcoming state, so ready never
   // depends combinationally on the downstream ready.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         o_ready <= (state_d == S_IDLE);
         o_valid <= (state_d == S_DONE);
         o_busy  <= (state_d == S_CONV);
      end
   end

   // Serial datapath: capture on accept, one magnitude bit per CONV cycle,
   // result loaded on the last bit and held through DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         sreg     <= '0;
         mag      <= '0;
         sign     <= 1'b0;
         seen_one <= 1'b0;
         o_data   <= '0;
         o_ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sreg     <= i_data[N-2:0];
                  sign     <= i_data[N-1];
                  cnt      <= '0;
                  seen_one <= 1'b0;
                  mag      <= '0;
               end
            end
            S_CONV: begin
               sreg     <= sreg >> 1;
               mag      <= {out_bit, mag[N-2:1]};
               seen_one <= seen_one_d;
               cnt      <= cnt + 1'b1;
               if (last_bit) begin
                  if (sign && !seen_one_d) begin
                     o_data <= {1'b1, {(N-1){1'b1}}};
                     o_ovf  <= 1'b1;
                  end else begin
                     o_data <= {sign, out_bit, mag[N-2:1]};
                     o_ovf  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (i_ready) o_ovf <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_q_twos_to_signmag.sv
// Directed bench for q_twos_to_signmag (N=16, Q=8).
module tb_q_twos_to_signmag;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [15:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_ovf;
   logic        o_busy;
   logic [1:0]  o_state;

   int n_checks = 0;
   int n_fail   = 0;

   q_twos_to_signmag #(.N(16), .Q(8)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_ovf   (o_ovf),
      .o_busy  (o_busy),
      .o_state (o_state)
   );

   // Clock: rising edges at 5, 15, 25, ...; outputs sampled on falling edges.
   always #5 i_clk = ~i_clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One conversion: offer din, measure latency, check result, optional
   // backpressure for bp cycles, then complete the output handshake.
   // scramble keeps i_valid high with fresh i_data every CONV cycle.
   // rdy_early holds i_ready high before o_valid rises.
   task automatic convert(input logic [15:0] din, input logic [15:0] exp,
                          input logic exp_ovf, input bit scramble,
                          input int bp, input bit rdy_early);
      int lat;
      int stray;
      lat   = 0;
      stray = 0;
      @(negedge i_clk);
      chk("ready_idle", o_ready, 1'b1);
      i_data  = din;
      i_valid = 1'b1;
      i_ready = rdy_early;
      @(posedge i_clk);
      for (int c = 0; c < 40; c++) begin
         @(negedge i_clk);
         if (o_valid) break;
         if (o_ready) stray++;
         i_valid = scramble;
         i_data  = 16'($urandom);
         @(posedge i_clk);
         lat++;
      end
      i_valid = 1'b0;
      chk("latency", lat, 15);
      chk("valid", o_valid, 1'b1);
      chk("data", o_data, exp);
      chk("ovf", o_ovf, exp_ovf);
      chk("no_ready_in_conv", stray, 0);
      chk("ready_done", o_ready, 1'b0);
      chk("busy_done", o_busy, 1'b0);
      if (!rdy_early) begin
         for (int b = 0; b < bp; b++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("bp_valid", o_valid, 1'b1);
            chk("bp_data", o_data, exp);
            chk("bp_ovf", o_ovf, exp_ovf);
            chk("bp_ready", o_ready, 1'b0);
         end
         i_ready = 1'b1;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      chk("valid_drop", o_valid, 1'b0);
      chk("ready_back", o_ready, 1'b1);
      chk("ovf_clear", o_ovf, 1'b0);
      i_ready = 1'b0;
   endtask

   initial begin
      int spurious;
      i_rst_n = 1'b0;
      i_data  = '0;
      i_valid = 1'b0;
      i_ready = 1'b0;

      // Reset state.
      #12;
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_ovf", o_ovf, 1'b0);
      chk("rst_data", o_data, 16'h0000);
      chk("rst_state", o_state, 2'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Main conversions.
      convert(16'h0100, 16'h0100, 1'b0, 1'b0, 0, 1'b0);  // +1.0
      convert(16'hFF00, 16'h8100, 1'b0, 1'b0, 0, 1'b1);  // -1.0, ready early
      convert(16'hFFFF, 16'h8001, 1'b0, 1'b0, 0, 1'b0);  // -2^-8
      convert(16'h8001, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
      convert(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);  // zero stays positive
      convert(16'hC000, 16'hC000, 1'b0, 1'b0, 0, 1'b1);  // -16384
      convert(16'h8000, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);  // saturate
      convert(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 0, 1'b0);  // flag cleared

      // Backpressure for 10 cycles.
      convert(16'hFE80, 16'h8180, 1'b0, 1'b0, 10, 1'b0);

      // Input changes with i_valid held during CONV.
      convert(16'h1234, 16'h1234, 1'b0, 1'b1, 0, 1'b0);
      convert(16'hEDCC, 16'h9234, 1'b0, 1'b1, 3, 1'b0);

      // Reset in the middle of CONV, after bit 5.
      @(negedge i_clk);
      i_data  = 16'hABCD;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (6) @(posedge i_clk);
      #2;
      chk("pre_rst_busy", o_busy, 1'b1);
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_ready", o_ready, 1'b1);
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_data", o_data, 16'h0000);
      chk("mid_rst_ovf", o_ovf, 1'b0);
      chk("mid_rst_state", o_state, 2'd0);
      @(negedge i_clk);
      i_rst_n  = 1'b1;
      spurious = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge i_clk);
         if (o_valid || !o_ready) spurious++;
      end
      chk("no_stale_valid", spurious, 0);
      convert(16'hFF80, 16'h8080, 1'b0, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
